writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 67 ++++++
 rtl/writeback_unit.sv | 107 ++++++++++
 tb/tb_writeback_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit and its pending-write queue.
// No logic; pure declarations.
// Imported by wb_fifo and writeback_unit.
package wb_pkg;

  localparam int         WB_DEPTH_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  // One pending register-file write.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write queue with two enqueue ports (port 0 lands ahead of port 1) and one dequeue.
// Latency: an entry pushed on edge N is visible at the head / in the ordered view from cycle N+1.
// Backpressure: none internally; the caller must never push more entries than there is room for.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push0,
  input  wb_entry_t               push0_dat,
  input  logic                    push1,
  input  wb_entry_t               push1_dat,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [CW-1:0]           count,
  output wb_entry_t [DEPTH-1:0]   ord,
  output logic [DEPTH-1:0]        ord_vld
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr1;
  logic [CW-1:0]         count_q, count_d;

  // Next state: port 0 writes at the tail, port 1 right behind it; pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    wr_ptr1 = wr_ptr_q + AW'(push0);
    if (push0) mem_d[wr_ptr_q] = push0_dat;
    if (push1) mem_d[wr_ptr1]  = push1_dat;
    wr_ptr_d = wr_ptr1 + AW'(push1);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Queue state; reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Age-ordered view of the queue: index 0 is the oldest entry, higher indices are younger.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord[i]     = mem_q[rd_ptr_q + AW'(i)];
      ord_vld[i] = (CW'(i) < count_q);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU and load results into an in-order queue that retires one register write per cycle.
// Latency: result accepted on edge N appears on the write port in cycle N+1 at the earliest. Forwarding only with WB_FORWARD_EN.
// Backpressure: alu_ready while a slot is free; ld_ready only if a slot remains after the ALU takes one.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteSelect,
  output logic        WriteEnable,
  input  logic [4:0]  ReadSelect1,
  input  logic [4:0]  ReadSelect2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data2,
  output logic [31:0] busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             head;
  logic [CW-1:0]         count;
  wb_entry_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]      ord_vld;
  logic [CW-1:0]         free;
  logic                  we;
  logic                  push0, push1;
  wb_entry_t             push0_dat, push1_dat;

  // Arbitration: the head retires every cycle, so its slot counts as free; x0 writes are dropped.
  always_comb begin
    we        = (count != '0);
    free      = CW'(DEPTH) - count + CW'(we);
    alu_ready = (free >= CW'(1));
    ld_ready  = (free >= (CW'(1) + CW'(alu_valid && alu_ready)));
    push0     = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    push1     = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    push0_dat = '{rd: alu_rd, data: alu_data};
    push1_dat = '{rd: ld_rd,  data: ld_data};
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push0     (push0),
    .push0_dat (push0_dat),
    .push1     (push1),
    .push1_dat (push1_dat),
    .pop       (we),
    .head      (head),
    .count     (count),
    .ord       (ord),
    .ord_vld   (ord_vld)
  );

  assign WriteEnable = we;
  assign WriteSelect = we ? head.rd   : REG_ZERO;
  assign WriteData   = we ? head.data : '0;

  // Scoreboard: one bit per register with a write still in flight.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i]) busy[ord[i].rd] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Forwarding: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ord_vld[i] && (ReadSelect1 != REG_ZERO) && (ord[i].rd == ReadSelect1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ord[i].data;
      end
      if (ord_vld[i] && (ReadSelect2 != REG_ZERO) && (ord[i].rd == ReadSelect2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ord[i].data;
      end
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;
  logic unused_fwd;
  assign unused_fwd = ^{ReadSelect1, ReadSelect2, ord};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [31:0] WriteData;
  logic [4:0]  WriteSelect;
  logic        WriteEnable;
  logic [4:0]  ReadSelect1, ReadSelect2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [31:0] busy;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .WriteData   (WriteData),
    .WriteSelect (WriteSelect),
    .WriteEnable (WriteEnable),
    .ReadSelect1 (ReadSelect1),
    .ReadSelect2 (ReadSelect2),
    .fwd_hit1    (fwd_hit1),
    .fwd_data1   (fwd_data1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data2   (fwd_data2),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected pending writes, oldest first.
  wb_entry_t q[$];
  logic m_ar, m_lr;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic        e_we;
    logic [4:0]  e_sel;
    logic [31:0] e_dat;
    logic        e_ar;
    logic        e_lr;
    logic [31:0] e_busy;
    logic        e_hit;
    logic [31:0] e_fd;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic [4:0] r1, input logic e_we, input logic [4:0] e_sel,
                              input logic [31:0] e_dat, input logic e_ar, input logic e_lr,
                              input logic [31:0] e_busy, input logic e_hit, input logic [31:0] e_fd);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld; v.r1 = r1;
    v.e_we = e_we; v.e_sel = e_sel; v.e_dat = e_dat; v.e_ar = e_ar; v.e_lr = e_lr;
    v.e_busy = e_busy; v.e_hit = e_hit; v.e_fd = e_fd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ld;
    ReadSelect1 = r1; ReadSelect2 = r2;
  endtask

  // Compare every output against the reference queue; called away from the clock edge.
  task automatic model_check();
    int          sz;
    int          free;
    logic [31:0] bm;
    logic        h1, h2;
    logic [31:0] d1, d2;
    sz   = q.size();
    free = DEPTH - sz + ((sz > 0) ? 1 : 0);
    m_ar = (free >= 1);
    m_lr = (free >= 1 + ((alu_valid && m_ar) ? 1 : 0));
    bm = '0; h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
    foreach (q[i]) begin
      bm[q[i].rd] = 1'b1;
      if (ReadSelect1 != 5'd0 && q[i].rd == ReadSelect1) begin h1 = 1'b1; d1 = q[i].data; end
      if (ReadSelect2 != 5'd0 && q[i].rd == ReadSelect2) begin h2 = 1'b1; d2 = q[i].data; end
    end
    if (!FWD) begin h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0; end
    check("sb_we",    32'(WriteEnable), 32'(sz > 0));
    check("sb_sel",   32'(WriteSelect), (sz > 0) ? 32'(q[0].rd) : 32'h0);
    check("sb_data",  WriteData,        (sz > 0) ? q[0].data : 32'h0);
    check("sb_ardy",  32'(alu_ready),   32'(m_ar));
    check("sb_lrdy",  32'(ld_ready),    32'(m_lr));
    check("sb_busy",  busy,             bm);
    check("sb_hit1",  32'(fwd_hit1),    32'(h1));
    check("sb_fd1",   fwd_data1,        d1);
    check("sb_hit2",  32'(fwd_hit2),    32'(h2));
    check("sb_fd2",   fwd_data2,        d2);
  endtask

  // Take the clock edge: the head retires, accepted nonzero-rd results join in ALU-then-load order.
  task automatic advance();
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (alu_valid && m_ar && alu_rd != 5'd0) q.push_back('{rd: alu_rd, data: alu_data});
    if (ld_valid && m_lr && ld_rd != 5'd0)   q.push_back('{rd: ld_rd, data: ld_data});
    #1;
  endtask

  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    drive(av, ar, ad, lv, lr, ld, r1, r2);
    @(negedge clk);
    model_check();
    advance();
  endtask

  initial begin
    logic [4:0]  ra, rl, s1, s2;
    logic [31:0] da, dl;
    logic        va, vl;

    //          av    ar     ad          lv    lr     ld          r1     we    sel    dat         ardy  lrdy  busy        hit   fd
    tbl[0]  = mk(1'b1, 5'd1, 32'hF000, 1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd1, 1'b1, 5'd1, 32'hF000, 1'b1, 1'b1, 32'h2,  FWD,  FWD ? 32'hF000 : 32'h0);
    tbl[2]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 5'd5, 32'h5678, 1'b1, 5'd4, 32'h4567, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 1'b1, 5'd5, 32'h5678, 1'b1, 1'b1, 32'h30, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 1'b1, 5'd4, 32'h4567, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[7]  = mk(1'b1, 5'd0, 32'h0123, 1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[9]  = mk(1'b1, 5'd3, 32'h3456, 1'b1, 5'd3, 32'h1111, 5'd3, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd3, 1'b1, 5'd3, 32'h3456, 1'b1, 1'b1, 32'h8,  FWD,  FWD ? 32'h1111 : 32'h0);
    tbl[11] = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd3, 1'b1, 5'd3, 32'h1111, 1'b1, 1'b1, 32'h8,  FWD,  FWD ? 32'h1111 : 32'h0);
    tbl[12] = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd3, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 32'h0,  1'b0, 32'h0);

    // Reset values while rst is held.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #3;
    check("rst_we",   32'(WriteEnable), 32'h0);
    check("rst_sel",  32'(WriteSelect), 32'h0);
    check("rst_data", WriteData,        32'h0);
    check("rst_busy", busy,             32'h0);
    check("rst_ardy", 32'(alu_ready),   32'h1);
    check("rst_lrdy", 32'(ld_ready),    32'h1);
    check("rst_hit1", 32'(fwd_hit1),    32'h0);
    check("rst_hit2", 32'(fwd_hit2),    32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed single-cycle vectors with hand-derived expectations.
    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].av, tbl[k].ar, tbl[k].ad, tbl[k].lv, tbl[k].lr, tbl[k].ld, tbl[k].r1, 5'd0);
      @(negedge clk);
      check($sformatf("t%0d_we", k),   32'(WriteEnable), 32'(tbl[k].e_we));
      check($sformatf("t%0d_sel", k),  32'(WriteSelect), 32'(tbl[k].e_sel));
      check($sformatf("t%0d_data", k), WriteData,        tbl[k].e_dat);
      check($sformatf("t%0d_ardy", k), 32'(alu_ready),   32'(tbl[k].e_ar));
      check($sformatf("t%0d_lrdy", k), 32'(ld_ready),    32'(tbl[k].e_lr));
      check($sformatf("t%0d_busy", k), busy,             tbl[k].e_busy);
      check($sformatf("t%0d_hit1", k), 32'(fwd_hit1),    32'(tbl[k].e_hit));
      check($sformatf("t%0d_fd1", k),  fwd_data1,        tbl[k].e_fd);
      model_check();
      advance();
    end

    // Both sources held valid: queue saturates, load gets throttled, nothing is lost.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 5'(1 + i % 7), 32'hA000 + 32'(i), 1'b1, 5'(16 + i % 9), 32'hB000 + 32'(i), 5'(1 + i % 7), 5'(16 + i % 9));
      if (i == 5) check("sat_lrdy_low", 32'(q.size()), 32'(DEPTH));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Random traffic including x0 destinations and forwarding snoops.
    for (int i = 0; i < 300; i++) begin
      va = 1'($urandom_range(0, 1));
      vl = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      rl = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      da = $urandom;
      dl = $urandom;
      s1 = 5'($urandom_range(0, 6));
      s2 = 5'($urandom_range(0, 6));
      cycle(va, ra, da, vl, rl, dl, s1, s2);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Fill three entries, then assert reset between edges.
    cycle(1'b1, 5'd6, 32'h6666, 1'b1, 5'd7, 32'h7777, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'h9999, 1'b1, 5'd10, 32'hAAAA, 5'd0, 5'd0);
    check("pre_rst_depth", 32'(q.size()), 32'd3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    @(negedge clk);
    check("pre_rst_we", 32'(WriteEnable), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("arst_we",   32'(WriteEnable), 32'h0);
    check("arst_sel",  32'(WriteSelect), 32'h0);
    check("arst_data", WriteData,        32'h0);
    check("arst_busy", busy,             32'h0);
    check("arst_ardy", 32'(alu_ready),   32'h1);
    check("arst_lrdy", 32'(ld_ready),    32'h1);
    check("arst_hit1", 32'(fwd_hit1),    32'h0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    cycle(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
